mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS32 pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs. It contains:
- the word-addressed data memory;
- branch resolution (PCSrc and target to IF);
- a wait-state controller that stalls upstream stages for slow memory;
- the MEM/WB pipeline register feeding write-back.

## Interface
- ADDR_W, 8, data memory word-address width (DEPTH = 2**ADDR_W words of 32 bits)
- WAIT_CYCLES, 0, extra cycles per aligned load/store (0..15)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- zero_in  in  1  ALU zero flag from EX/MEM
- branch, memread, memtoreg, memwrite, regwrite  in  1 each  control bits from EX/MEM
- branch_target_in  in  32  computed branch address from EX/MEM
- write_data_in  in  32  store data (rt value) from EX/MEM
- alu_result_in  in  32  byte address for loads/stores, or ALU result
- write_register_in  in  5  destination register from EX/MEM
- pcsrc  out  1  branch taken to IF (combinational)
- branch_target_out  out  32  equals branch_target_in (combinational)
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle (combinational)
- read_data_out  out  32  MEM/WB: load data
- alu_result_out  out  32  MEM/WB: ALU result
- write_register_out  out  5  MEM/WB: destination register
- o_memtoreg, o_regwrite  out  1 each  MEM/WB control
- misalign_out  out  1  MEM/WB: access was misaligned and suppressed

## Operation
- **Word index.** idx = alu_result_in[ADDR_W+1:2]. Upper address bits are ignored, so the index wraps modulo DEPTH.
- **Access condition.**
  - access = (memread | memwrite) & (alu_result_in[1:0] == 0).
  - misaligned = (memread | memwrite) & (alu_result_in[1:0] != 0).
- **Misaligned handling.**
  - No write and no stall.
  - MEM/WB captures read_data_out=0, o_regwrite=0, misalign_out=1.
- **Branch resolution.**
  - pcsrc = branch & zero_in.
  - Independent of stall. Branches never access memory.
- **Wait-state FSM.** States IDLE and BUSY, with a 4-bit counter cnt.
  - IDLE, access & WAIT_CYCLES>0: stall=1, go BUSY, cnt <= WAIT_CYCLES-1.
  - IDLE, otherwise: stall=0, commit this edge.
  - BUSY, cnt!=0: stall=1, cnt <= cnt-1.
  - BUSY, cnt==0: stall=0, commit this edge, go IDLE.
- **Commit** (rising edge with stall=0, reset=0):
  - If access & memwrite: mem[idx] <= write_data_in.
  - MEM/WB loads from inputs. read_data_out <= mem[idx] (value before any same-edge write) when access & memread, else 0.
  - misalign_out <= misaligned.
  - o_regwrite <= regwrite & ~(misaligned & memread).
- **Simultaneous memread & memwrite.** Illegal from decode. Defined anyway: the write happens and read_data_out gets the old word.
- **Stall edge** (stall=1):
  - MEM/WB loads a bubble: o_regwrite=0, o_memtoreg=0, misalign_out=0; data fields 0.
  - No memory write.
  - Upstream must hold EX/MEM inputs stable while stall=1.
- **Reset.**
  - All MEM/WB outputs become 0. FSM goes to IDLE, cnt=0.
  - Memory contents are not cleared.
  - Reset during BUSY aborts the access; the pending store is never written.

## Timing
- WAIT_CYCLES=0:
  - Single-cycle stage; stall is constantly 0.
  - MEM/WB outputs are valid one cycle after the inputs are presented.
- WAIT_CYCLES=N>0:
  - An aligned access occupies N+1 cycles, with stall high for the first N.
  - Commit happens at the end of cycle N+1.
  - MEM/WB shows the result in cycle N+2.
  - The preceding N edges produce bubbles.
- Back-to-back accesses:
  - The FSM returns to IDLE at the commit edge.
  - The next access starts stalling immediately; there is no idle gap.
- Store then load, same index, consecutive instructions: the load returns the new data, because the write committed on the earlier edge.
- pcsrc, branch_target_out and stall are combinational from the current inputs and state. They have no added latency.

## Test plan
- **Reset.** Assert reset 2 cycles with random inputs. Required: all MEM/WB outputs 0, stall=0.
- **Store/load, WAIT_CYCLES=0.**
  - Stimulus: store 0xDEADBEEF at addr 0x10, then load 0x10 with regwrite=1, memtoreg=1, write_register=5.
  - Required: next cycle read_data_out=0xDEADBEEF, write_register_out=5, o_regwrite=1.
- **Wrap.**
  - Stimulus: ADDR_W=8, store 0x1234 at addr 0x400, then load addr 0x0.
  - Required: read_data_out=0x1234.
- **Misaligned load.**
  - Stimulus: load at 0x13 with regwrite=1.
  - Required: misalign_out=1, o_regwrite=0, read_data_out=0, stall stays 0, memory unchanged.
- **Wait states.**
  - Stimulus: WAIT_CYCLES=2, store 0xA5A5A5A5 at 0x20.
  - Required: stall=1 for exactly 2 cycles, 2 bubbles in MEM/WB, memory written only on the 3rd edge.
  - Stimulus: assert reset in the 2nd stall cycle and retry the load at 0x20.
  - Required: the old value is returned; the store is never written.
- **Branch.**
  - Stimulus: branch=1, zero_in=1, target 0x00400020.
  - Required: pcsrc=1 in the same cycle, branch_target_out=0x00400020.
  - Stimulus: zero_in=0.
  - Required: pcsrc=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB, branch and stall outputs of the memory stage
interface mem_stage_if;
  logic        zero_in;
  logic        branch;
  logic        memread;
  logic        memtoreg;
  logic        memwrite;
  logic        regwrite;
  logic [31:0] branch_target_in;
  logic [31:0] write_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  write_register_in;
  logic        pcsrc;
  logic [31:0] branch_target_out;
  logic        stall;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  write_register_out;
  logic        o_memtoreg;
  logic        o_regwrite;
  logic        misalign_out;
  modport master (
    output zero_in, branch, memread, memtoreg, memwrite, regwrite,
           branch_target_in, write_data_in, alu_result_in, write_register_in,
    input  pcsrc, branch_target_out, stall, read_data_out, alu_result_out,
           write_register_out, o_memtoreg, o_regwrite, misalign_out
  );
  modport slave (
    input  zero_in, branch, memread, memtoreg, memwrite, regwrite,
           branch_target_in, write_data_in, alu_result_in, write_register_in,
    output pcsrc, branch_target_out, stall, read_data_out, alu_result_out,
           write_register_out, o_memtoreg, o_regwrite, misalign_out
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS32 MEM stage with data memory, branch resolution, wait states and MEM/WB register
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input logic       clock,
  input logic       reset,
  mem_stage_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              rw, access, misaligned, stall, commit_store;
  assign idx          = bus.alu_result_in[ADDR_W+1:2];
  assign rw           = bus.memread | bus.memwrite;
  assign access       = rw & (bus.alu_result_in[1:0] == 2'b00);
  assign misaligned   = rw & (bus.alu_result_in[1:0] != 2'b00);
  assign commit_store = ~reset & ~stall & access & bus.memwrite;
  assign bus.pcsrc             = bus.branch & bus.zero_in;
  assign bus.branch_target_out = bus.branch_target_in;
  assign bus.stall             = stall;
  always_comb begin
    stall   = state == BUSY ? cnt != 4'd0 : access && (WAIT_CYCLES > 0);
    state_n = state == BUSY ? (stall ? BUSY : IDLE) : (stall ? BUSY : IDLE);
    cnt_n   = state == BUSY ? (stall ? cnt - 4'd1 : cnt) : (stall ? CNT_INIT : cnt);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  always_ff @(posedge clock) begin
    if (commit_store) mem[idx] <= bus.write_data_in;
  end
  always_ff @(posedge clock) begin
    if (reset || stall) begin
      bus.read_data_out      <= 32'd0;
      bus.alu_result_out     <= 32'd0;
      bus.write_register_out <= 5'd0;
      bus.o_memtoreg         <= 1'b0;
      bus.o_regwrite         <= 1'b0;
      bus.misalign_out       <= 1'b0;
    end else begin
      bus.read_data_out      <= (access & bus.memread) ? mem[idx] : 32'd0;
      bus.alu_result_out     <= bus.alu_result_in;
      bus.write_register_out <= bus.write_register_in;
      bus.o_memtoreg         <= bus.memtoreg;
      bus.o_regwrite         <= bus.regwrite & ~(misaligned & bus.memread);
      bus.misalign_out       <= misaligned;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a transaction-level model
module tb_mem_stage;
  typedef struct packed {
    logic br, zero, mr, mw, m2r, rw;
    logic [31:0] tgt, wd, addr;
    logic [4:0] wr;
  } txn_t;
  typedef struct packed {
    logic [31:0] rd, alu;
    logic [4:0] wr;
    logic m2r, rw, mis;
  } mw_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] m0 [256];
  logic [31:0] m2 [256];

  mem_stage_if if0();
  mem_stage_if if2();
  mem_stage #(.ADDR_W(8), .WAIT_CYCLES(0)) u0 (.clock(clock), .reset(reset), .bus(if0));
  mem_stage #(.ADDR_W(8), .WAIT_CYCLES(2)) u2 (.clock(clock), .reset(reset), .bus(if2));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic txn_t mk(logic mr, logic mw, logic [31:0] addr, logic [31:0] wd,
                              logic m2r, logic rw, logic [4:0] wr);
    txn_t t = '0;
    t.mr = mr; t.mw = mw; t.addr = addr; t.wd = wd; t.m2r = m2r; t.rw = rw; t.wr = wr;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t = '0;
    int k = int'($urandom_range(7));
    int kind = int'($urandom_range(4));
    logic [31:0] a = ($urandom & 32'hFFFF_FC00) | (32'(k) << 2);
    t.tgt = $urandom; t.wd = $urandom; t.wr = 5'($urandom);
    t.zero = 1'($urandom); t.m2r = 1'($urandom); t.rw = 1'($urandom);
    t.addr = a;
    if (kind == 0) t.mw = 1'b1;
    else if (kind == 1) t.mr = 1'b1;
    else if (kind == 2) begin
      t.addr = a | 32'($urandom_range(1, 3));
      if ($urandom_range(1) == 0) t.mr = 1'b1; else t.mw = 1'b1;
    end else if (kind == 3) t.addr = $urandom;
    else t.br = 1'b1;
    return t;
  endfunction

  function automatic int key(txn_t t);
    return int'((t.addr >> 2) % 256);
  endfunction

  function automatic bit aligned_access(txn_t t);
    return (t.mr || t.mw) && (t.addr % 4 == 0);
  endfunction

  // Expected MEM/WB contents of a committed transaction, given the word held at its index
  function automatic mw_t predict(txn_t t, logic [31:0] word);
    mw_t e;
    logic mis = (t.mr || t.mw) && (t.addr % 4 != 0);
    e.rd = (t.mr && !mis) ? word : 32'd0;
    e.alu = t.addr;
    e.wr = t.wr;
    e.m2r = t.m2r;
    e.rw = t.rw && !(mis && t.mr);
    e.mis = mis;
    return e;
  endfunction

  function automatic mw_t obs0();
    return {if0.read_data_out, if0.alu_result_out, if0.write_register_out,
            if0.o_memtoreg, if0.o_regwrite, if0.misalign_out};
  endfunction

  function automatic mw_t obs2();
    return {if2.read_data_out, if2.alu_result_out, if2.write_register_out,
            if2.o_memtoreg, if2.o_regwrite, if2.misalign_out};
  endfunction

  task automatic set0(input txn_t t);
    if0.branch = t.br; if0.zero_in = t.zero; if0.memread = t.mr; if0.memwrite = t.mw;
    if0.memtoreg = t.m2r; if0.regwrite = t.rw; if0.branch_target_in = t.tgt;
    if0.write_data_in = t.wd; if0.alu_result_in = t.addr; if0.write_register_in = t.wr;
  endtask

  task automatic set2(input txn_t t);
    if2.branch = t.br; if2.zero_in = t.zero; if2.memread = t.mr; if2.memwrite = t.mw;
    if2.memtoreg = t.m2r; if2.regwrite = t.rw; if2.branch_target_in = t.tgt;
    if2.write_data_in = t.wd; if2.alu_result_in = t.addr; if2.write_register_in = t.wr;
  endtask

  task automatic run0(input string name, input txn_t t);
    mw_t e;
    set0(t);
    #1;
    checks++;
    if (if0.stall !== 1'b0 || if0.pcsrc !== (t.br & t.zero) || if0.branch_target_out !== t.tgt) begin
      failures++;
      $display("FAIL %s_comb: stall=%b pcsrc=%b tgt=%h required stall=0 pcsrc=%b tgt=%h",
               name, if0.stall, if0.pcsrc, if0.branch_target_out, t.br & t.zero, t.tgt);
    end
    e = predict(t, m0[key(t)]);
    if (aligned_access(t) && t.mw) m0[key(t)] = t.wd;
    @(posedge clock); #1;
    checks++;
    if (obs0() !== e) begin
      failures++;
      $display("FAIL %s_memwb: got %h required %h", name, obs0(), e);
    end
  endtask

  task automatic run2(input string name, input txn_t t);
    mw_t e;
    int n = 0;
    int want = aligned_access(t) ? 2 : 0;
    set2(t);
    #1;
    checks++;
    if (if2.pcsrc !== (t.br & t.zero) || if2.branch_target_out !== t.tgt) begin
      failures++;
      $display("FAIL %s_branch: pcsrc=%b tgt=%h required pcsrc=%b tgt=%h",
               name, if2.pcsrc, if2.branch_target_out, t.br & t.zero, t.tgt);
    end
    e = predict(t, m2[key(t)]);
    while (if2.stall === 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
      checks++;
      if (obs2() !== '0) begin
        failures++;
        $display("FAIL %s_bubble%0d: got %h required 0", name, n, obs2());
      end
    end
    checks++;
    if (n != want) begin
      failures++;
      $display("FAIL %s_stalls: got %0d stall cycles required %0d", name, n, want);
    end
    if (aligned_access(t) && t.mw) m2[key(t)] = t.wd;
    @(posedge clock); #1;
    checks++;
    if (obs2() !== e) begin
      failures++;
      $display("FAIL %s_memwb: got %h required %h", name, obs2(), e);
    end
  endtask

  task automatic test_reset();
    txn_t t;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set0(rnd());
      t = rnd(); t.mr = 1'b0; t.mw = 1'b0;
      set2(t);
      @(posedge clock); #1;
      checks++;
      if (obs0() !== '0 || obs2() !== '0 || if0.stall !== 1'b0 || if2.stall !== 1'b0) begin
        failures++;
        $display("FAIL reset%0d: memwb0=%h memwb2=%h stall0=%b stall2=%b required all 0",
                 i, obs0(), obs2(), if0.stall, if2.stall);
      end
    end
    set0('0);
    set2('0);
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    run0("store_deadbeef", mk(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0));
    run0("load_deadbeef", mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd5));
    checks++;
    if (if0.read_data_out !== 32'hDEAD_BEEF || if0.write_register_out !== 5'd5 || if0.o_regwrite !== 1'b1) begin
      failures++;
      $display("FAIL load_direct: rd=%h wr=%0d regwrite=%b required DEADBEEF 5 1",
               if0.read_data_out, if0.write_register_out, if0.o_regwrite);
    end
  endtask

  task automatic test_wrap();
    run0("store_wrap", mk(1'b0, 1'b1, 32'h400, 32'h1234, 1'b0, 1'b0, 5'd0));
    run0("load_wrap", mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd9));
    checks++;
    if (if0.read_data_out !== 32'h1234) begin
      failures++;
      $display("FAIL wrap_direct: rd=%h required 00001234", if0.read_data_out);
    end
  endtask

  task automatic test_misaligned();
    run0("mis_load", mk(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 5'd7));
    checks++;
    if (if0.misalign_out !== 1'b1 || if0.o_regwrite !== 1'b0 || if0.read_data_out !== 32'h0) begin
      failures++;
      $display("FAIL mis_direct: mis=%b regwrite=%b rd=%h required 1 0 0",
               if0.misalign_out, if0.o_regwrite, if0.read_data_out);
    end
    run0("mis_store", mk(1'b0, 1'b1, 32'h13, 32'h0BAD_0BAD, 1'b0, 1'b0, 5'd0));
    run0("mis_reload", mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd3));
    checks++;
    if (if0.read_data_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mis_unchanged: rd=%h required DEADBEEF", if0.read_data_out);
    end
  endtask

  task automatic test_branch();
    txn_t t = '0;
    t.br = 1'b1; t.zero = 1'b1; t.tgt = 32'h0040_0020;
    set0(t);
    #1;
    checks++;
    if (if0.pcsrc !== 1'b1 || if0.branch_target_out !== 32'h0040_0020) begin
      failures++;
      $display("FAIL branch_taken: pcsrc=%b tgt=%h required 1 00400020", if0.pcsrc, if0.branch_target_out);
    end
    if0.zero_in = 1'b0;
    #1;
    checks++;
    if (if0.pcsrc !== 1'b0) begin
      failures++;
      $display("FAIL branch_not_taken: pcsrc=%b required 0", if0.pcsrc);
    end
    @(posedge clock); #1;
    set0('0);
  endtask

  task automatic test_random0();
    for (int k = 0; k < 8; k++)
      run0("pre0", mk(1'b0, 1'b1, 32'(k) << 2, $urandom, 1'b0, 1'b0, 5'd0));
    for (int i = 0; i < 40; i++) run0("rand0", rnd());
    set0('0);
  endtask

  task automatic test_wait_states();
    txn_t t;
    run2("ws_old", mk(1'b0, 1'b1, 32'h20, 32'h1111_2222, 1'b0, 1'b0, 5'd0));
    // Abort: reset lands in the second stall cycle of a store
    set2(mk(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0, 1'b0, 5'd0));
    @(posedge clock); #1;
    checks++;
    if (if2.stall !== 1'b1) begin
      failures++;
      $display("FAIL abort_stall: stall=%b required 1", if2.stall);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    set2('0);
    run2("ws_after_abort", mk(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd4));
    checks++;
    if (if2.read_data_out !== 32'h1111_2222) begin
      failures++;
      $display("FAIL abort_old_value: rd=%h required 11112222", if2.read_data_out);
    end
    run2("ws_store", mk(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0, 1'b0, 5'd0));
    run2("ws_load", mk(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd6));
    checks++;
    if (if2.read_data_out !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL ws_new_value: rd=%h required A5A5A5A5", if2.read_data_out);
    end
    for (int k = 0; k < 8; k++)
      run2("pre2", mk(1'b0, 1'b1, 32'(k) << 2, $urandom, 1'b0, 1'b0, 5'd0));
    for (int i = 0; i < 20; i++) begin
      t = rnd();
      run2("rand2", t);
    end
    set2('0);
  endtask

  initial begin
    set0('0);
    set2('0);
    test_reset();
    test_store_load();
    test_wrap();
    test_misaligned();
    test_branch();
    test_random0();
    test_wait_states();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
